// File: rtl/wav_i2s_tx.sv
// wav_i2s_tx: plays 16-bit stereo PCM from a byte FIFO as an I2S stream.
// Bytes arrive little-endian (L lo, L hi, R lo, R hi) into a 4-byte buffer.
// The serializer emits one 32-bit frame per 32 BCLK periods, with data one
// BCLK behind the word-select edge. A frame that starts without a complete
// sample is sent as zeros and flagged with a one-clk underrun pulse.
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset
//   enable        playback enable, level-sensitive
//   fifo_empty    byte FIFO empty flag
//   fifo_rd_en    FIFO read strobe, one clk wide
//   fifo_rd_data  FIFO read data, valid one clk after fifo_rd_en
//   i2s_bclk      I2S bit clock
//   i2s_lrck      I2S word select (0 = left, 1 = right)
//   i2s_sdata     I2S serial data, MSB first
//   underrun      one-clk pulse when a zero frame is sent
module wav_i2s_tx #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       fifo_empty,
  output logic       fifo_rd_en,
  input  logic [7:0] fifo_rd_data,
  output logic       i2s_bclk,
  output logic       i2s_lrck,
  output logic       i2s_sdata,
  output logic       underrun
);

  localparam int unsigned DIV_W   = 8;
  localparam int unsigned BIT_W   = 5;
  localparam int unsigned IDX_W   = 2;
  localparam int unsigned FRAME_W = 32;

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_RD   = 2'd1,
    F_CAP  = 2'd2
  } fetch_state_t;

  fetch_state_t         state_q;
  fetch_state_t         state_d;
  logic [IDX_W-1:0]     byte_idx_q;
  logic                 buf_full_q;
  logic [7:0]           byte_q [4];
  logic [DIV_W-1:0]     div_q;
  logic [BIT_W-1:0]     bit_q;
  logic [FRAME_W-1:0]   frame_q;

  logic                 tick_c;
  logic                 load_c;
  logic [BIT_W-1:0]     bit_next_c;
  logic [FRAME_W-1:0]   sample_c;

  assign tick_c     = enable && (div_q == DIV_W'(CLK_DIV - 1));
  assign load_c     = tick_c && i2s_bclk && (bit_q == '0);
  assign bit_next_c = bit_q + BIT_W'(1);
  assign sample_c   = {byte_q[1], byte_q[0], byte_q[3], byte_q[2]};

  // Fetch state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= F_IDLE;
    else     state_q <= state_d;
  end

  // Fetch next-state and read strobe. The strobe is gated by the live empty
  // flag so a stale "not empty" seen a clk earlier can never cause a read of
  // an empty FIFO; the FSM simply waits in F_RD until data is there.
  always_comb begin
    state_d    = state_q;
    fifo_rd_en = 1'b0;
    case (state_q)
      F_IDLE: if (enable && !buf_full_q && !fifo_empty) state_d = F_RD;
      F_RD: begin
        if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          state_d    = F_CAP;
        end else if (!enable) begin
          state_d = F_IDLE;
        end
      end
      F_CAP:   state_d = F_IDLE;
      default: state_d = F_IDLE;
    endcase
  end

  // Sample buffer; a frame load that consumes the buffer wins over a fetch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_idx_q <= '0;
      buf_full_q <= 1'b0;
      for (int i = 0; i < 4; i++) byte_q[i] <= '0;
    end else if (load_c && buf_full_q) begin
      buf_full_q <= 1'b0;
      byte_idx_q <= '0;
    end else if (state_q == F_CAP) begin
      byte_q[byte_idx_q] <= fifo_rd_data;
      byte_idx_q         <= byte_idx_q + IDX_W'(1);
      if (byte_idx_q == IDX_W'(3)) buf_full_q <= 1'b1;
    end
  end

  // BCLK divider, bit counter and frame shifter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q     <= '0;
      bit_q     <= '0;
      frame_q   <= '0;
      i2s_bclk  <= 1'b0;
      i2s_lrck  <= 1'b0;
      i2s_sdata <= 1'b0;
      underrun  <= 1'b0;
    end else if (!enable) begin
      div_q     <= '0;
      bit_q     <= '0;
      frame_q   <= '0;
      i2s_bclk  <= 1'b0;
      i2s_lrck  <= 1'b0;
      i2s_sdata <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (tick_c) begin
        div_q    <= '0;
        i2s_bclk <= ~i2s_bclk;
        if (i2s_bclk) begin
          bit_q    <= bit_next_c;
          i2s_lrck <= bit_next_c[BIT_W-1];
          if (bit_q == '0) begin
            if (buf_full_q) begin
              frame_q   <= sample_c;
              i2s_sdata <= sample_c[FRAME_W-1];
            end else begin
              frame_q   <= '0;
              i2s_sdata <= 1'b0;
              underrun  <= 1'b1;
            end
          end else begin
            // Rotate rather than shift; the register is reloaded every frame
            i2s_sdata <= frame_q[FRAME_W-2];
            frame_q   <= {frame_q[FRAME_W-2:0], frame_q[FRAME_W-1]};
          end
        end
      end else begin
        div_q <= div_q + DIV_W'(1);
      end
    end
  end

endmodule
